seg_scan_sched: RTL and testbench
=================================

Name: seg_scan_sched

Overview:
- Scan scheduler for the 6-digit multiplexed seven-segment display on sys_clk (50 MHz).
- Accepts a binary value, decimal-point mask, sign and enable, and converts the value to BCD with a sequential double-dabble FSM.
- Owns the digit time-slicing: drives sel/seg one digit at a time, with leading-zero suppression, minus-sign placement and blanking.
- Sits between the application data source and the display pins, inside the display top.

Parameters:
- CNT_MAX, 49_999: digit dwell counter terminal value; (CNT_MAX+1) sys_clk cycles per digit, 1 ms at 50 MHz.
- DATA_MAX, 999_999: clamp ceiling for the input value.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  asynchronous active-low reset.
- data  in  20  unsigned value to display.
- point  in  6  decimal-point mask; bit k lights dp of digit k.
- sign  in  1  1 = display minus sign.
- seg_en  in  1  1 = display on, 0 = all digits dark.
- conv_busy  out  1  BCD conversion in progress.
- sel  out  6  digit select, one-hot active-high; bit 0 = rightmost (least significant) digit.
- seg  out  8  segment drive, active-low; bit 7 = dp, bits 6..0 = g..a.

Behaviour:
- Reset (async, sys_rst_n=0): sel=6'b000000, seg=8'hFF, conv_busy=0, dwell counter=0, digit index=0, BCD buffer = all zero, last-converted value=0.
- Clamp: value used = min(data, DATA_MAX).
- Converter FSM, states IDLE -> SHIFT -> DONE -> IDLE.
  - IDLE: if clamped data != last-converted value, capture it, conv_busy=1, go to SHIFT.
  - SHIFT: exactly 20 cycles; each cycle add 3 to every BCD nibble >=5, then shift left one bit, bringing in the next data MSB.
  - DONE: one cycle; copy all 6 nibbles to the display buffer atomically, store last-converted value, conv_busy=0, go to IDLE.
  - Latency: result reaches the buffer 22 cycles after the IDLE detect cycle.
  - data changing during SHIFT is ignored; it is re-compared in the next IDLE and reconverted if different.
  - The display never shows a partially converted value.
- Dwell counter: 0..CNT_MAX, wraps to 0. At CNT_MAX the digit index advances 0,1,..,5,0.
- Output stage: one register. sel/seg reflect the digit index one cycle after the index changes.
  - sel = 1 << index when seg_en=1.
- Blanking: digit k (k>0) is blank when buffer digits k..5 are all 0 and point[k..5] are all 0. Digit 0 is never blanked, so value 0 shows "0".
- Sign: with sign=1, the minus sign is drawn at m = (highest non-blank digit)+1 when m<=5. When m=6 the sign is dropped.
- Segment codes:
  - digits 0..9 = C0, F9, A4, B0, 99, 92, 82, F8, 80, 90;
  - minus = BF; blank = FF;
  - point[k]=1 clears bit 7 on digit k. dp still lights on a digit that shows minus or is blank.
- seg_en=0: sel=6'b000000, seg=8'hFF from the next cycle. Dwell counter, index and converter keep running. Re-enabling resumes at the current index with no restart.
- Reset mid-conversion or mid-dwell: immediate return to the reset values. After release, conversion of the current data starts if data != 0.

Test Plan:
- Bench overrides CNT_MAX=9.
- Reset held 30 ns, data=0, seg_en=1 -> after release: sel sequence 01,02,04,08,10,20, each held 10 cycles; seg=C0 on digit 0 and FF on digits 1..5; conv_busy stays 0.
- data=123456, point=0, sign=0 -> conv_busy high for 21 cycles. Then digits 0..5 show 82,92,99,B0,A4,F9.
- data=1_048_575 -> clamped to 999999; every digit shows 90.
- data=42, sign=1, point=6'b000100 -> digit0=A4, digit1=99, digit2=40 (0 with dp, kept by point), digit3=BF, digits 4-5=FF.
- data changed 100->200 during SHIFT -> buffer first shows 100, then a second conversion runs and the buffer shows 200. There are no intermediate glyphs.
- seg_en pulsed low for 15 cycles mid-scan -> sel=00, seg=FF during the pulse. After the pulse the index continues from the dwell-counter position, with the scan cadence unchanged.

Source files
------------

// File: rtl/seg_scan_sched.sv
// Six-digit multiplexed seven-segment scan scheduler with a sequential
// double-dabble binary-to-BCD converter, leading-zero blanking and sign placement.
module seg_scan_sched #(
  parameter int unsigned CNT_MAX  = 49_999,
  parameter int unsigned DATA_MAX = 999_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        sign,
  input  logic        seg_en,
  output logic        conv_busy,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  localparam int unsigned CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

  conv_state_t   state;
  logic [19:0]   data_clamp;
  logic [19:0]   shreg;
  logic [19:0]   cap_val;
  logic [19:0]   last_val;
  logic [23:0]   bcd;
  logic [23:0]   bcd_adj;
  logic [23:0]   disp;
  logic [4:0]    bit_cnt;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [5:0]    blank;
  logic [5:0]    minus_here;
  logic [3:0]    digit;
  logic [7:0]    glyph;

  assign data_clamp = (data > 20'(DATA_MAX)) ? 20'(DATA_MAX) : data;

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 6; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // The display buffer is only written in DONE, so a half-shifted value is never visible.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      cap_val   <= '0;
      last_val  <= '0;
      bcd       <= '0;
      disp      <= '0;
      bit_cnt   <= '0;
      conv_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_clamp != last_val) begin
            cap_val   <= data_clamp;
            shreg     <= data_clamp;
            bcd       <= '0;
            bit_cnt   <= '0;
            conv_busy <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          bcd     <= {bcd_adj[22:0], shreg[19]};
          shreg   <= {shreg[18:0], 1'b0};
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd19) state <= DONE;
        end
        DONE: begin
          disp      <= bcd;
          last_val  <= cap_val;
          conv_busy <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(CNT_MAX)) begin
      cnt <= '0;
      idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Blanking is monotone upward, so the sign sits on the lowest blank digit.
  always_comb begin
    blank      = '0;
    minus_here = '0;
    blank[5]   = (disp[23:20] == 4'd0) && !point[5];
    for (int unsigned k = 4; k >= 1; k--) begin
      blank[k] = (disp[4*k +: 4] == 4'd0) && !point[k] && blank[k+1];
    end
    for (int unsigned k = 1; k < 6; k++) begin
      minus_here[k] = sign && blank[k] && !blank[k-1];
    end
  end

  always_comb begin
    digit = disp[{idx, 2'b00} +: 4];
    case (digit)
      4'd0:    glyph = 8'hC0;
      4'd1:    glyph = 8'hF9;
      4'd2:    glyph = 8'hA4;
      4'd3:    glyph = 8'hB0;
      4'd4:    glyph = 8'h99;
      4'd5:    glyph = 8'h92;
      4'd6:    glyph = 8'h82;
      4'd7:    glyph = 8'hF8;
      4'd8:    glyph = 8'h80;
      4'd9:    glyph = 8'h90;
      default: glyph = 8'hFF;
    endcase
    if (minus_here[idx])  glyph = 8'hBF;
    else if (blank[idx])  glyph = 8'hFF;
    if (point[idx])       glyph[7] = 1'b0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sel <= '0;
      seg <= '1;
    end else if (seg_en) begin
      sel <= 6'b000001 << idx;
      seg <= glyph;
    end else begin
      sel <= '0;
      seg <= '1;
    end
  end

endmodule

// File: tb/tb_seg_scan_sched.sv
// Directed bench for seg_scan_sched with a shortened dwell (CNT_MAX=9).
module tb_seg_scan_sched;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        seg_en;
  logic        conv_busy;
  logic [5:0]  sel;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;

  seg_scan_sched #(.CNT_MAX(9), .DATA_MAX(999_999)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .data(data), .point(point),
    .sign(sign), .seg_en(seg_en), .conv_busy(conv_busy), .sel(sel), .seg(seg)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic seek(input logic [5:0] v, input string tag);
    int n = 0;
    while (sel !== v && n < 80) begin
      @(negedge sys_clk);
      n++;
    end
    chk({tag, "_found"}, 32'(sel), 32'(v));
  endtask

  task automatic show(input int k, input logic [7:0] exp_seg, input string tag);
    logic [5:0] v;
    v = 6'b000001 << k;
    seek(v, tag);
    chk({tag, "_seg"}, 32'(seg), 32'(exp_seg));
  endtask

  task automatic dwell(input int k, input logic [7:0] exp_seg, input string tag);
    logic [5:0] v;
    int run = 0;
    v = 6'b000001 << k;
    show(k, exp_seg, tag);
    while (sel === v && run < 50) begin
      run++;
      @(negedge sys_clk);
    end
    chk({tag, "_dwell"}, 32'(run), 32'd10);
  endtask

  task automatic busy_rise(input string tag);
    int n = 0;
    while (conv_busy !== 1'b1 && n < 10) begin
      @(negedge sys_clk);
      n++;
    end
    chk({tag, "_busy_rise"}, 32'(conv_busy), 32'd1);
  endtask

  task automatic busy_len(output int len);
    len = 0;
    while (conv_busy === 1'b1 && len < 60) begin
      len++;
      @(negedge sys_clk);
    end
  endtask

  task automatic conv(input string tag);
    int len;
    busy_rise(tag);
    busy_len(len);
    chk({tag, "_busy_len"}, 32'(len), 32'd21);
    @(negedge sys_clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int len;
    int gap;
    int bad;
    data = '0; point = '0; sign = 1'b0; seg_en = 1'b1; sys_rst_n = 1'b0;
    #20;
    chk("rst_sel", 32'(sel), 32'h00);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_busy", 32'(conv_busy), 32'd0);
    #10 sys_rst_n = 1'b1;

    dwell(0, 8'hC0, "zero_d0");
    for (int k = 1; k < 6; k++) dwell(k, 8'hFF, "zero_blank");
    chk("zero_no_conv", 32'(conv_busy), 32'd0);

    data = 20'd123456;
    conv("v123456");
    show(0, 8'h82, "v123456_d0");
    show(1, 8'h92, "v123456_d1");
    show(2, 8'h99, "v123456_d2");
    show(3, 8'hB0, "v123456_d3");
    show(4, 8'hA4, "v123456_d4");
    show(5, 8'hF9, "v123456_d5");

    data = 20'd1_048_575;
    conv("clamp");
    for (int k = 0; k < 6; k++) show(k, 8'h90, "clamp_d");

    data = 20'd42; sign = 1'b1; point = 6'b000100;
    conv("v42");
    show(0, 8'hA4, "v42_d0");
    show(1, 8'h99, "v42_d1");
    show(2, 8'h40, "v42_d2");
    show(3, 8'hBF, "v42_minus");
    show(4, 8'hFF, "v42_d4");
    show(5, 8'hFF, "v42_d5");

    sign = 1'b0; point = '0; data = 20'd100;
    busy_rise("midchg");
    repeat (4) @(negedge sys_clk);
    data = 20'd200;
    busy_len(len);
    chk("midchg_first_len", 32'(len), 32'd17);
    gap = 0;
    while (conv_busy !== 1'b1 && gap < 10) begin
      gap++;
      @(negedge sys_clk);
    end
    chk("midchg_gap", 32'(gap), 32'd1);
    busy_len(len);
    chk("midchg_second_len", 32'(len), 32'd21);
    @(negedge sys_clk);
    show(0, 8'hC0, "v200_d0");
    show(1, 8'hC0, "v200_d1");
    show(2, 8'hA4, "v200_d2");
    show(3, 8'hFF, "v200_d3");

    seek(6'h20, "en_sync");
    seek(6'h01, "en_start");
    repeat (3) @(negedge sys_clk);
    seg_en = 1'b0;
    bad = 0;
    repeat (15) begin
      @(negedge sys_clk);
      if (sel !== 6'h00 || seg !== 8'hFF) bad++;
    end
    chk("en_off_dark", 32'(bad), 32'd0);
    seg_en = 1'b1;
    @(negedge sys_clk);
    chk("en_resume_sel", 32'(sel), 32'h02);
    @(negedge sys_clk);
    dwell(2, 8'hA4, "en_cadence");

    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_sel", 32'(sel), 32'h00);
    chk("midrst_seg", 32'(seg), 32'hFF);
    chk("midrst_busy", 32'(conv_busy), 32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    conv("post_rst");
    show(2, 8'hA4, "post_rst_d2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
